// File: rtl/ram_arbiter_pkg.sv
// Shared constants for the two-master RAM arbiter: master indices, default widths
// and the read-tag state encoding.
package ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_M0   = 2'd1,
        RD_M1   = 2'd2
    } rd_state_t;

endpackage

// File: rtl/ram_arbiter_pick.sv
// Combinational 2-way picker. Round robin on a tie when RAM_ARB_RR_EN is defined,
// otherwise fixed priority with m0 always winning.
module ram_arbiter_pick
    import ram_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

`ifdef RAM_ARB_RR_EN
    // On a tie the master that did not win last time goes first.
    assign gnt0 = req0 & (~req1 | (last_grant == M1));
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign gnt0 = req0;
`endif

    assign gnt1 = req1 & ~gnt0;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM port between m0 (CPU) and m1 (DMA). Registers the issue,
// pulses the ack and returns tagged read data two cycles after arbitration.
// Build option: RAM_ARB_RR_EN selects round robin instead of fixed m0 priority.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              run;
    logic              elig0, elig1;
    logic              gnt0, gnt1, gnt_any;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              last_grant;
    rd_state_t         rd_state, rd_next;

    // Reset is released synchronously: nothing is arbitrated on the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) run <= 1'b0;
        else          run <= 1'b1;
    end

    // The master acked this cycle is masked so a held request is never issued twice.
    assign elig0 = run & m0_req & ~m0_ack;
    assign elig1 = run & m1_req & ~m1_ack;

    ram_arbiter_pick u_pick (
        .req0       (elig0),
        .req1       (elig1),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign gnt_any   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? m1_we    : m0_we;
    assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
    assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            last_grant <= M1;
        end else begin
            m0_ack <= gnt0;
            m1_ack <= gnt1;
            ram_we <= gnt_any & sel_we;
            if (gnt_any) begin
                ram_addr   <= sel_addr;
                ram_wdata  <= sel_wdata;
                last_grant <= gnt1 ? M1 : M0;
            end
        end
    end

    // Read tag: remembers who owns the read the RAM is servicing this cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rd_state <= RD_IDLE;
        else          rd_state <= rd_next;
    end

    always_comb begin
        rd_next = RD_IDLE;
        if (gnt_any && !sel_we) rd_next = gnt1 ? RD_M1 : RD_M0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= (rd_state == RD_M0);
            m1_rvalid <= (rd_state == RD_M1);
        end
    end

    // RAM output is live in the rvalid cycle, so data is steered rather than re-registered.
    assign m0_rdata = m0_rvalid ? ram_rdata : '0;
    assign m1_rdata = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a spec-level arbitration model predicts acks and issues,
// and a read scoreboard checks every rvalid cycle against the owner and data expected.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [15:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_ack, m0_rvalid;
    logic [15:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [15:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_ack, m1_rvalid;
    logic [15:0] m1_rdata;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic        owner;
        logic [15:0] data;
        int          due;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [15:0] exp_mem [int];
    logic [15:0] ram_mem [0:4095];
    bit          ram_wr  [0:4095];

    logic        x_ack0, x_ack1, x_lg, run_m;
    logic [15:0] x_addr, x_wdata;

    ram_arbiter dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_ack    (m0_ack),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_ack    (m1_ack),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a[11:0] == 12'h010) ? 16'hBEEF : ({4'h0, a[11:0]} ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] exp_lookup(input logic [15:0] a);
        int k = int'(a[11:0]);
        return exp_mem.exists(k) ? exp_mem[k] : init_val(a);
    endfunction

    // Registered-read RAM with a 4K window.
    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr[11:0]] <= ram_wdata;
            ram_wr[ram_addr[11:0]]  <= 1'b1;
        end
        ram_rdata <= ram_wr[ram_addr[11:0]] ? ram_mem[ram_addr[11:0]] : init_val(ram_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Read scoreboard: each cycle either the due read returns or both rvalids are low.
    always @(negedge clk) begin
        if (rd_q.size() != 0 && rd_q[0].due == cyc) begin
            rd_exp_t e;
            e = rd_q.pop_front();
            check("rvalid0", 32'(m0_rvalid), 32'(!e.owner));
            check("rvalid1", 32'(m1_rvalid), 32'(e.owner));
            check("rdata0", 32'(m0_rdata), e.owner ? 32'h0 : 32'(e.data));
            check("rdata1", 32'(m1_rdata), e.owner ? 32'(e.data) : 32'h0);
        end else begin
            check("idle_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
            check("idle_rdata", {m1_rdata, m0_rdata}, 32'h0);
        end
    end

    task automatic model_reset();
        x_ack0 = 1'b0;
        x_ack1 = 1'b0;
        x_lg   = 1'b1;
        run_m  = 1'b0;
        x_addr = '0;
        x_wdata = '0;
        rd_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {27'h0, m0_ack, m1_ack, m0_rvalid, m1_rvalid, ram_we}, 32'h0);
        check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 32'h0);
        check({tag, "_ram"}, {ram_addr, ram_wdata}, 32'h0);
    endtask

    // One clock: predict the arbitration from the current inputs, advance, compare.
    task automatic step();
        logic e0, e1, g0, g1, wsel;
        logic [15:0] a, d;
        e0 = run_m & m0_req & ~x_ack0;
        e1 = run_m & m1_req & ~x_ack1;
`ifdef RAM_ARB_RR_EN
        g0 = e0 & (~e1 | x_lg);
`else
        g0 = e0;
`endif
        g1 = e1 & ~g0;
        wsel = 1'b0;
        if (g0 | g1) begin
            wsel = g1 ? m1_we : m0_we;
            a    = g1 ? m1_addr : m0_addr;
            d    = g1 ? m1_wdata : m0_wdata;
            x_addr  = a;
            x_wdata = d;
            x_lg    = g1;
            if (wsel) exp_mem[int'(a[11:0])] = d;
            else      rd_q.push_back('{owner: g1, data: exp_lookup(a), due: cyc + 2});
        end
        @(posedge clk);
        run_m = rst_n;
        @(negedge clk);
        check("ack0", 32'(m0_ack), 32'(g0));
        check("ack1", 32'(m1_ack), 32'(g1));
        check("ram_we", 32'(ram_we), 32'((g0 | g1) & wsel));
        check("ram_addr", 32'(ram_addr), 32'(x_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(x_wdata));
        x_ack0 = g0;
        x_ack1 = g1;
    endtask

    initial begin
        model_reset();

        // Reset held with both masters requesting.
        m0_req = 1'b1; m0_addr = 16'h0100;
        m1_req = 1'b1; m1_addr = 16'h0200;
        step();
        check_all_zero("rst_hold");
        step();
        rst_n = 1'b1;
        step();
        step();
        // m1 gives up before it is ever acked: nothing must be issued for it.
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) step();

        // m0 read of the preloaded word.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 16'h0010;
        step();
        m0_req = 1'b0;
        repeat (3) step();

        // m1 write then read back.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0020; m1_wdata = 16'h1234;
        step();
        m1_req = 1'b0;
        step();
        m1_req = 1'b1; m1_we = 1'b0;
        step();
        m1_req = 1'b0;
        repeat (3) step();

        // Both masters stream reads; each moves to the next word after its ack.
        m0_req = 1'b1; m0_addr = 16'h0100;
        m1_req = 1'b1; m1_addr = 16'h0300;
        for (int i = 0; i < 12; i++) begin
            step();
            if (x_ack0) m0_addr = m0_addr + 16'd1;
            if (x_ack1) m1_addr = m1_addr + 16'd1;
        end

        // m0 streams, m1 only requests on even cycles.
        for (int i = 0; i < 12; i++) begin
            m1_req = (i % 2 == 0);
            step();
            if (x_ack0) m0_addr = m0_addr + 16'd1;
            if (x_ack1) m1_addr = m1_addr + 16'd1;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (3) step();

        // Reset lands while a read is in flight: its rvalid must never appear.
        m0_req = 1'b1; m0_addr = 16'h0010;
        step();
        m0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();

        check("scoreboard_drained", 32'(rd_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
